// File: rtl/jelly_stream_unpack.sv
`default_nettype none
// jelly_stream_unpack: splits each packed N-unit input word into one output beat per unit,
// with each unit broken into up to four fields. Rev 1.0 - initial release.
module jelly_stream_unpack #(
   parameter  int N    = 4,
   parameter  int W0   = 8,
   parameter  int W1   = 8,
   parameter  int W2   = 0,
   parameter  int W3   = 0,
   localparam int c_UW = W0 + W1 + W2 + W3,
   localparam int c_UB = (c_UW > 0) ? c_UW : 1,
   localparam int c_B0 = (W0 > 0) ? W0 : 1,
   localparam int c_B1 = (W1 > 0) ? W1 : 1,
   localparam int c_B2 = (W2 > 0) ? W2 : 1,
   localparam int c_B3 = (W3 > 0) ? W3 : 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              aclken,
   input  logic [N*c_UB-1:0] s_data,
   input  logic              s_last,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [c_B0-1:0]   m_data0,
   output logic [c_B1-1:0]   m_data1,
   output logic [c_B2-1:0]   m_data2,
   output logic [c_B3-1:0]   m_data3,
   output logic              m_first,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready
);

   localparam int              c_IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);
   localparam int              c_O1   = W0;
   localparam int              c_O2   = W0 + W1;
   localparam int              c_O3   = W0 + W1 + W2;

   logic [N*c_UB-1:0] r_hold;
   logic              r_slast;
   logic [c_IW-1:0]   r_idx;
   logic              r_valid;
   logic              r_first;
   logic              r_last;
   logic [c_B0-1:0]   r_d0;
   logic [c_B1-1:0]   r_d1;
   logic [c_B2-1:0]   r_d2;
   logic [c_B3-1:0]   r_d3;

   logic              w_at_last;
   logic              w_in_hs;
   logic              w_out_hs;
   logic [c_IW-1:0]   w_nidx;
   logic [c_UB-1:0]   w_unit;
   logic [c_B0-1:0]   w_f0;
   logic [c_B1-1:0]   w_f1;
   logic [c_B2-1:0]   w_f2;
   logic [c_B3-1:0]   w_f3;

   assign w_at_last = (r_idx == c_LAST);
   assign s_ready   = aclken & (~r_valid | (m_ready & w_at_last));
   assign w_in_hs   = s_valid & s_ready;
   assign w_out_hs  = aclken & r_valid & m_ready;
   assign w_nidx    = w_at_last ? '0 : r_idx + 1'b1;

   // A new word presents unit 0 straight from the bus; otherwise advance through the held word.
   assign w_unit = w_in_hs ? s_data[c_UB-1:0] : r_hold[w_nidx*c_UB +: c_UB];

   generate
      if (W0 > 0) begin : g_f0
         assign w_f0 = w_unit[0 +: W0];
      end else begin : g_f0_zero
         assign w_f0 = '0;
      end
      if (W1 > 0) begin : g_f1
         assign w_f1 = w_unit[c_O1 +: W1];
      end else begin : g_f1_zero
         assign w_f1 = '0;
      end
      if (W2 > 0) begin : g_f2
         assign w_f2 = w_unit[c_O2 +: W2];
      end else begin : g_f2_zero
         assign w_f2 = '0;
      end
      if (W3 > 0) begin : g_f3
         assign w_f3 = w_unit[c_O3 +: W3];
      end else begin : g_f3_zero
         assign w_f3 = '0;
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_hold  <= '0;
         r_slast <= 1'b0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
         r_d0    <= '0;
         r_d1    <= '0;
         r_d2    <= '0;
         r_d3    <= '0;
      end else if (aclken) begin
         if (w_in_hs) begin
            r_hold  <= s_data;
            r_slast <= s_last;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= (N == 1) & s_last;
            r_d0    <= w_f0;
            r_d1    <= w_f1;
            r_d2    <= w_f2;
            r_d3    <= w_f3;
         end else if (w_out_hs) begin
            if (!w_at_last) begin
               r_idx   <= w_nidx;
               r_first <= 1'b0;
               r_last  <= (w_nidx == c_LAST) & r_slast;
               r_d0    <= w_f0;
               r_d1    <= w_f1;
               r_d2    <= w_f2;
               r_d3    <= w_f3;
            end else begin
               r_valid <= 1'b0;
               r_idx   <= '0;
            end
         end
      end
   end

   assign m_data0 = r_d0;
   assign m_data1 = r_d1;
   assign m_data2 = r_d2;
   assign m_data3 = r_d3;
   assign m_first = r_first;
   assign m_last  = r_last;
   assign m_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/jelly_stream_unpack.md
Name: jelly_stream_unpack

Overview:
- Streaming inverse of the team's field packer.
- Accepts one packed word per handshake. Each word holds N units, and each unit holds up to four fields of width W0..W3. Any field width may be zero.
- Emits one unit per output beat, split back into separate field outputs, with first/last markers.
- Sits between a wide packed bus (FIFO or DMA side) and per-element processing pipelines.

Parameters:
- N, 4, units per input word; must be >= 1.
- W0, 8, width of field 0 in bits; 0 allowed.
- W1, 8, width of field 1 in bits; 0 allowed.
- W2, 0, width of field 2 in bits; 0 allowed.
- W3, 0, width of field 3 in bits; 0 allowed.
- UW (local), W0+W1+W2+W3, unit width. UB = max(UW,1) and Bk = max(Wk,1) are the physical port widths.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- aclken, in, 1, clock enable. Low freezes all state.
- s_data, in, N*UB, packed word. Unit i is at [i*UB +: UB]. Inside a unit, field0 is at the LSBs, then field1, field2, field3.
- s_last, in, 1, marks the final word of a frame.
- s_valid, in, 1, input valid.
- s_ready, out, 1, input ready.
- m_data0, out, B0, field 0 of the current unit.
- m_data1, out, B1, field 1 of the current unit.
- m_data2, out, B2, field 2 of the current unit.
- m_data3, out, B3, field 3 of the current unit.
- m_first, out, 1, high when the current unit is unit 0 of its word.
- m_last, out, 1, high when the current unit is unit N-1 of a word accepted with s_last=1.
- m_valid, out, 1, output valid.
- m_ready, in, 1, output ready.

Behaviour:
- Reset (aresetn low, async): m_valid=0, m_first=0, m_last=0, all m_data*=0, unit index=0, holding register cleared, frame-last flag cleared.
- State:
  - holding register (N*UB bits), latched s_last, unit index idx in 0..N-1, output register stage.
  - The block is busy from word acceptance until the unit N-1 beat handshakes.
- Ready rule:
  - s_ready = aclken & (~m_valid | (m_ready & idx==N-1)). This is combinational from m_ready.
- Input handshake (s_valid & s_ready, aclken=1):
  - latch s_data and s_last;
  - load the unit 0 fields into m_data*;
  - m_valid<=1, m_first<=1, idx<=0;
  - m_last<=1 only when N==1 and s_last=1.
  - Latency from input handshake to first output valid is 1 cycle.
- Output handshake (m_valid & m_ready, aclken=1):
  - If idx<N-1: idx<=idx+1, present unit idx+1, m_first<=0, m_last<=(idx+1==N-1) & latched s_last.
  - If idx==N-1 and s_valid=1: the next word is loaded that same cycle with no bubble. Sustained throughput is 1 unit/cycle.
  - If idx==N-1 and s_valid=0: m_valid<=0, idx<=0.
- Backpressure:
  - While m_valid=1 and m_ready=0, m_data*, m_first and m_last are held stable.
  - No input is accepted unless the last unit is leaving.
- Field extraction:
  - field k of unit i = s_data[i*UB + (W0+..+W(k-1)) +: Wk].
  - A field with Wk==0 drives m_datak=0 constantly.
  - If UW==0, all data outputs are 0, but handshakes, first and last still operate.
- aclken=0: no state change, s_ready=0, outputs hold. m_ready is ignored in that cycle (no beat is consumed).
- Reset asserted mid-word: the remaining units of that word are discarded. After release the block is idle and s_ready=1.
- N==1: the block degenerates to a single register slice with field split. m_first=1 on every beat, m_last=s_last.

Test Plan:
- Basic unpack:
  - Stimulus: N=4, W0=W1=8, W2=W3=0, m_ready=1; one word s_data=0x0807_0605_0403_0201, s_last=1.
  - Required: four beats with (m_data0,m_data1) = (01,02), (03,04), (05,06), (07,08). m_first is high on beat 0 only; m_last is high on beat 3 only.
  - Then m_valid=0 and s_ready=1.
- Back-to-back words:
  - Stimulus: 3 words, s_valid held high, m_ready=1.
  - Required: 12 consecutive valid beats with no gap. s_ready is high only in the cycles where idx==3 or the block is idle.
- Backpressure:
  - Stimulus: toggle m_ready as 1,0,0,1 repeating.
  - Required: each unit is held stable until accepted; no unit is lost or duplicated; output order is 01,03,05,07 on m_data0.
- Zero-width and odd fields:
  - Stimulus: N=2, W0=3, W1=0, W2=5, W3=0; unit0 = 0b10110_101.
  - Required: m_data0=5, m_data1=0, m_data2=0x16, m_data3=0.
- Clock enable and reset:
  - Stimulus 1: drop aclken for 5 cycles mid-word.
    - Required: outputs frozen and s_ready=0; the sequence resumes intact afterwards.
  - Stimulus 2: assert aresetn low after beat 1 of 4.
    - Required: m_valid=0 immediately (async). After release, the first beat out is unit 0 of the next accepted word.
- N=1:
  - Stimulus: words A,B,C sent with s_last on C.
  - Required: 1-cycle latency per beat, m_first=1 on every beat, m_last=1 only on C.
